// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Latency counter width; MUL_LAT is limited to 0..7.
  localparam int CNT_W = 3;

  // Width needed to index n requesters, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_rr_arbiter.sv
// Combinational round-robin arbiter: scans from rr_ptr upward with wrap
// and grants the first requester found.
module mult_rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  // Pick the first active request at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one external WIDTH x WIDTH multiplier among NUM_REQ requesters.
// Optional feature macro: MULT_ARB_PERF_EN adds a 16-bit completed-operation
// counter on output op_count.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]      req_a,
  input  logic [NUM_REQ*WIDTH-1:0]      req_b,
  output logic [WIDTH-1:0]              mul_a,
  output logic [WIDTH-1:0]              mul_b,
  input  logic [2*WIDTH-1:0]            mul_p,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [2*WIDTH-1:0]            resp_p,
  output logic [id_width(NUM_REQ)-1:0]  resp_id
`ifdef MULT_ARB_PERF_EN
  ,
  output logic [15:0]                   op_count
`endif
);

  localparam int ID_W = id_width(NUM_REQ);

  state_t             state;
  state_t             state_next;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_grant;
  logic [CNT_W-1:0]   cnt;

  mult_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: accept in IDLE, count down in BUSY, wait for consumer in RESP.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (any_grant) state_next = ST_BUSY;
      ST_BUSY: if (cnt == '0) state_next = ST_RESP;
      ST_RESP: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Only the arbiter winner sees ready, and only while idle.
  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE) req_ready = grant;
  end

  // Operand launch, latency countdown, product capture and response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      resp_p     <= '0;
      resp_id    <= '0;
      resp_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_grant) begin
            mul_a   <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
            mul_b   <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
            resp_id <= grant_idx;
            rr_ptr  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            cnt     <= CNT_W'(MUL_LAT);
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            resp_p     <= mul_p;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MULT_ARB_PERF_EN
  // Count completed response handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)                           op_count <= '0;
    else if (resp_valid && resp_ready) op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter (NUM_REQ=2, WIDTH=4, MUL_LAT=1).
// The multiplier is modelled as a one-stage pipeline so capture timing matters.
module tb_mult_share_arbiter;

  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 4;
  localparam int MUL_LAT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [7:0] mul_p;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_p;
  logic [0:0] resp_id;
`ifdef MULT_ARB_PERF_EN
  logic [15:0] op_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [1:0] valid;
    logic [3:0] a0, b0, a1, b1;
    logic       rdy;
    logic [1:0] exp_req_ready;
    logic       exp_resp_valid;
    logic [7:0] exp_p;
    logic       exp_id;
    logic       chk_mul;
    logic [3:0] exp_ma, exp_mb;
  } vec_t;

  vec_t vecs[24];

  mult_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_p     (resp_p),
`ifdef MULT_ARB_PERF_EN
    .op_count   (op_count),
`endif
    .resp_id    (resp_id)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // One-cycle registered multiplier standing in for the shared datapath.
  always @(posedge clk) mul_p <= {4'b0, mul_a} * {4'b0, mul_b};

  function automatic vec_t mk(input logic [1:0] valid, input logic [3:0] a0, input logic [3:0] b0,
                              input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] er,
                              input logic ev, input logic [7:0] ep, input logic eid,
                              input logic cm, input logic [3:0] ma, input logic [3:0] mb);
    vec_t v;
    v.valid = valid; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1; v.rdy = 1'b1;
    v.exp_req_ready = er; v.exp_resp_valid = ev; v.exp_p = ep; v.exp_id = eid;
    v.chk_mul = cm; v.exp_ma = ma; v.exp_mb = mb;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid  = v.valid;
    req_a      = {v.a1, v.a0};
    req_b      = {v.b1, v.b0};
    resp_ready = v.rdy;
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int row);
    check($sformatf("row%0d req_ready", row), 16'(req_ready), 16'(v.exp_req_ready));
    check($sformatf("row%0d onehot", row), 16'($countones(req_ready) <= 1), 16'd1);
    check($sformatf("row%0d resp_valid", row), 16'(resp_valid), 16'(v.exp_resp_valid));
    if (v.exp_resp_valid) begin
      check($sformatf("row%0d resp_p", row), 16'(resp_p), 16'(v.exp_p));
      check($sformatf("row%0d resp_id", row), 16'(resp_id), 16'(v.exp_id));
    end
    if (v.chk_mul) begin
      check($sformatf("row%0d mul_a", row), 16'(mul_a), 16'(v.exp_ma));
      check($sformatf("row%0d mul_b", row), 16'(mul_b), 16'(v.exp_mb));
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitResp(input string name, input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      if (resp_valid) break;
      stepCycle();
    end
    check({name, " resp timeout"}, 16'(resp_valid), 16'd1);
  endtask

  // Main sequence: reset, table rows, then multi-cycle corner cases.
  initial begin
    // Single requests: 3*4 from req0, then 15*15 from req1 with mul operands held.
    vecs[0]  = mk(2'b01, 4'd3, 4'd4, 4'd0, 4'd0, 2'b01, 1'b0, 8'd0,   1'b0, 1'b0, 4'd0,  4'd0);
    vecs[1]  = mk(2'b00, 4'd3, 4'd4, 4'd0, 4'd0, 2'b00, 1'b0, 8'd0,   1'b0, 1'b1, 4'd3,  4'd4);
    vecs[2]  = mk(2'b00, 4'd3, 4'd4, 4'd0, 4'd0, 2'b00, 1'b0, 8'd0,   1'b0, 1'b1, 4'd3,  4'd4);
    vecs[3]  = mk(2'b00, 4'd3, 4'd4, 4'd0, 4'd0, 2'b00, 1'b1, 8'd12,  1'b0, 1'b0, 4'd0,  4'd0);
    vecs[4]  = mk(2'b10, 4'd0, 4'd0, 4'd15, 4'd15, 2'b10, 1'b0, 8'd0,  1'b0, 1'b0, 4'd0,  4'd0);
    vecs[5]  = mk(2'b00, 4'd0, 4'd0, 4'd9, 4'd9, 2'b00, 1'b0, 8'd0,    1'b0, 1'b1, 4'd15, 4'd15);
    vecs[6]  = mk(2'b00, 4'd0, 4'd0, 4'd9, 4'd9, 2'b00, 1'b0, 8'd0,    1'b0, 1'b1, 4'd15, 4'd15);
    vecs[7]  = mk(2'b00, 4'd0, 4'd0, 4'd9, 4'd9, 2'b00, 1'b1, 8'd225,  1'b1, 1'b0, 4'd0,  4'd0);
    // Both requesters valid continuously: grants alternate 0,1,0,1.
    vecs[8]  = mk(2'b11, 4'd2, 4'd3, 4'd5, 4'd6, 2'b01, 1'b0, 8'd0,  1'b0, 1'b0, 4'd0, 4'd0);
    vecs[9]  = mk(2'b11, 4'd2, 4'd3, 4'd5, 4'd6, 2'b00, 1'b0, 8'd0,  1'b0, 1'b1, 4'd2, 4'd3);
    vecs[10] = mk(2'b11, 4'd2, 4'd3, 4'd5, 4'd6, 2'b00, 1'b0, 8'd0,  1'b0, 1'b1, 4'd2, 4'd3);
    vecs[11] = mk(2'b11, 4'd2, 4'd3, 4'd5, 4'd6, 2'b00, 1'b1, 8'd6,  1'b0, 1'b0, 4'd0, 4'd0);
    vecs[12] = mk(2'b11, 4'd2, 4'd3, 4'd5, 4'd6, 2'b10, 1'b0, 8'd0,  1'b0, 1'b0, 4'd0, 4'd0);
    vecs[13] = mk(2'b11, 4'd2, 4'd3, 4'd5, 4'd6, 2'b00, 1'b0, 8'd0,  1'b0, 1'b1, 4'd5, 4'd6);
    vecs[14] = mk(2'b11, 4'd2, 4'd3, 4'd5, 4'd6, 2'b00, 1'b0, 8'd0,  1'b0, 1'b1, 4'd5, 4'd6);
    vecs[15] = mk(2'b11, 4'd2, 4'd3, 4'd5, 4'd6, 2'b00, 1'b1, 8'd30, 1'b1, 1'b0, 4'd0, 4'd0);
    vecs[16] = mk(2'b11, 4'd2, 4'd3, 4'd5, 4'd6, 2'b01, 1'b0, 8'd0,  1'b0, 1'b0, 4'd0, 4'd0);
    vecs[17] = mk(2'b11, 4'd2, 4'd3, 4'd5, 4'd6, 2'b00, 1'b0, 8'd0,  1'b0, 1'b0, 4'd0, 4'd0);
    vecs[18] = mk(2'b11, 4'd2, 4'd3, 4'd5, 4'd6, 2'b00, 1'b0, 8'd0,  1'b0, 1'b0, 4'd0, 4'd0);
    vecs[19] = mk(2'b11, 4'd2, 4'd3, 4'd5, 4'd6, 2'b00, 1'b1, 8'd6,  1'b0, 1'b0, 4'd0, 4'd0);
    vecs[20] = mk(2'b11, 4'd2, 4'd3, 4'd5, 4'd6, 2'b10, 1'b0, 8'd0,  1'b0, 1'b0, 4'd0, 4'd0);
    vecs[21] = mk(2'b00, 4'd2, 4'd3, 4'd5, 4'd6, 2'b00, 1'b0, 8'd0,  1'b0, 1'b0, 4'd0, 4'd0);
    vecs[22] = mk(2'b00, 4'd2, 4'd3, 4'd5, 4'd6, 2'b00, 1'b0, 8'd0,  1'b0, 1'b0, 4'd0, 4'd0);
    vecs[23] = mk(2'b00, 4'd2, 4'd3, 4'd5, 4'd6, 2'b00, 1'b1, 8'd30, 1'b1, 1'b0, 4'd0, 4'd0);

    rst        = 1'b1;
    req_valid  = 2'b00;
    req_a      = 8'h00;
    req_b      = 8'h00;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset resp_valid", 16'(resp_valid), 16'd0);
    check("reset mul_a", 16'(mul_a), 16'd0);
    check("reset mul_b", 16'(mul_b), 16'd0);
    check("reset resp_p", 16'(resp_p), 16'd0);
    check("reset resp_id", 16'(resp_id), 16'd0);
    check("reset req_ready", 16'(req_ready), 16'd0);
`ifdef MULT_ARB_PERF_EN
    check("reset op_count", op_count, 16'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
      stepCycle();
    end

    // Back-pressure: response must hold for 5 stalled cycles, then accept in one.
    req_valid = 2'b01; req_a = 8'h07; req_b = 8'h09; resp_ready = 1'b0;
    #1;
    check("bp accept req_ready", 16'(req_ready), 16'd1);
    stepCycle();
    req_valid = 2'b00;
    waitResp("bp", 10);
    for (int k = 0; k < 5; k++) begin
      req_valid = 2'b10;
      #1;
      check($sformatf("bp%0d resp_valid", k), 16'(resp_valid), 16'd1);
      check($sformatf("bp%0d resp_p", k), 16'(resp_p), 16'd63);
      check($sformatf("bp%0d resp_id", k), 16'(resp_id), 16'd0);
      check($sformatf("bp%0d req_ready", k), 16'(req_ready), 16'd0);
      stepCycle();
    end
    req_valid = 2'b00; resp_ready = 1'b1;
    #1;
    check("bp pre-accept resp_valid", 16'(resp_valid), 16'd1);
    stepCycle();
    check("bp post-accept resp_valid", 16'(resp_valid), 16'd0);
`ifdef MULT_ARB_PERF_EN
    check("op_count after 7 ops", op_count, 16'd7);
`endif

    // Reset during BUSY: operation dropped, pointer back to 0, req1 then served.
    req_valid = 2'b01; req_a = 8'h03; req_b = 8'h05;
    stepCycle();
    req_valid = 2'b00;
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    check("midrst mul_a", 16'(mul_a), 16'd0);
`ifdef MULT_ARB_PERF_EN
    check("midrst op_count", op_count, 16'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      check($sformatf("midrst%0d resp_valid", k), 16'(resp_valid), 16'd0);
      stepCycle();
    end
    req_valid = 2'b11; req_a = 8'h60; req_b = 8'h70;
    #1;
    check("midrst rr_ptr zero", 16'(req_ready), 16'd1);
    req_valid = 2'b10;
    #1;
    check("midrst req1 ready", 16'(req_ready), 16'd2);
    stepCycle();
    req_valid = 2'b00;
    waitResp("midrst", 10);
    check("midrst resp_p", 16'(resp_p), 16'd42);
    check("midrst resp_id", 16'(resp_id), 16'd1);
    stepCycle();
    check("midrst drained", 16'(resp_valid), 16'd0);

`ifdef MULT_ARB_PERF_EN
    // Counter after one post-reset op, then cleared by reset.
    check("op_count post-reset op", op_count, 16'd1);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    check("op_count cleared", op_count, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
